// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
package mem_stage_pkg;

    // Controller occupancy: idle, bus access in flight, access complete.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit positions inside the 2-bit WB control bundle.
    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;

    // WB bundle inserted into MEM_WB while the stage is stalled.
    localparam logic [1:0] WB_BUBBLE = 2'b00;

endpackage

// File: rtl/mem_timeout_cnt.sv
// WAIT-cycle counter with expiry compare; used only in the MEM_TIMEOUT_EN build.
module mem_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Expiry fires in the WAIT cycle whose index is TIMEOUT_CYCLES-1.
    assign expired_c = en_i && (cnt_q == LAST);

    // Clear on WAIT entry, count each WAIT cycle, saturate at expiry.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory access controller between EX/MEM and MEM_WB.
// Optional build macro: MEM_TIMEOUT_EN (aborts a WAIT with no ack after TIMEOUT_CYCLES).
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [1:0]        WB_i,
    input  logic [DATA_W-1:0] ALU_data_i,
    input  logic [DATA_W-1:0] Store_data_i,
    input  logic [4:0]        RegWriteAddr_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              stall_o,
    output logic [1:0]        WB_o,
    output logic [DATA_W-1:0] MEM_data_o,
    output logic [DATA_W-1:0] ALU_data_o,
    output logic [4:0]        RegWriteAddr_o,
    output logic              err_o
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rdata_q;
    logic              issue_c;
    logic              ack_c;
    logic              abort_c;
    logic              stall_c;
    logic              expired_c;
    logic              mem_op_c;

    assign mem_op_c = MemRead_i | MemWrite_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and stall decode; ack takes priority over a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        issue_c = 1'b0;
        ack_c   = 1'b0;
        abort_c = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op_c) begin
                    stall_c = 1'b1;
                    issue_c = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (dmem_ack_i) begin
                    ack_c   = 1'b1;
                    state_d = DONE;
                end else if (expired_c) begin
                    abort_c = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pipeline-facing outputs are forced quiet while reset is held.
    assign stall_o        = rst_n_i & stall_c;
    assign WB_o           = (rst_n_i && !stall_c) ? WB_i : WB_BUBBLE;
    assign MEM_data_o     = rdata_q;
    assign ALU_data_o     = ALU_data_i;
    assign RegWriteAddr_o = RegWriteAddr_i;

    // Bus request launch/retire and load-data capture.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            rdata_q      <= '0;
        end else begin
            if (issue_c) begin
                dmem_req_o   <= 1'b1;
                dmem_we_o    <= MemWrite_i;
                dmem_addr_o  <= ADDR_W'({ALU_data_i[DATA_W-1:2], 2'b00});
                dmem_wdata_o <= Store_data_i;
            end else if (ack_c || abort_c) begin
                dmem_req_o <= 1'b0;
            end
            if (ack_c && !dmem_we_o) begin
                rdata_q <= dmem_rdata_i;
            end else if (abort_c) begin
                rdata_q <= '0;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    mem_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (issue_c),
        .en_i      (state_q == WAIT),
        .expired_c (expired_c)
    );

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_o <= 1'b0;
        end else if (abort_c) begin
            err_o <= 1'b1;
        end
    end
`else
    localparam int unsigned TIMEOUT_UNUSED = TIMEOUT_CYCLES;
    logic unused_cfg;

    assign unused_cfg = ^TIMEOUT_UNUSED;
    assign expired_c  = 1'b0;
    assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl (default build; timeout case under MEM_TIMEOUT_EN).
module tb_mem_stage_ctrl;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, dmem_ack;
    logic [1:0]  wb_in;
    logic [31:0] alu_in, store_data, dmem_rdata;
    logic [4:0]  rwa_in;
    logic        dmem_req, dmem_we, stall, err;
    logic [31:0] dmem_addr, dmem_wdata, mem_data, alu_out;
    logic [1:0]  wb_out;
    logic [4:0]  rwa_out;

    int checks   = 0;
    int failures = 0;
    logic [31:0] model_rdata;
    logic        prev_stall;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [4:0]  rwa;
        logic [1:0]  exp_wb;
        logic        exp_stall;
    } vec_t;

    typedef struct {
        logic [1:0]  wb;
        logic        stall;
        logic [31:0] alu;
        logic [4:0]  rwa;
    } vexp_t;

    vec_t  vecs[6];
    vexp_t vq[$];

    always #5 clk = ~clk;

    mem_stage_ctrl #(
        .DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .MemRead_i(mem_read), .MemWrite_i(mem_write), .WB_i(wb_in),
        .ALU_data_i(alu_in), .Store_data_i(store_data), .RegWriteAddr_i(rwa_in),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_wdata_o(dmem_wdata), .dmem_ack_i(dmem_ack), .dmem_rdata_i(dmem_rdata),
        .stall_o(stall), .WB_o(wb_out), .MEM_data_o(mem_data),
        .ALU_data_o(alu_out), .RegWriteAddr_o(rwa_out), .err_o(err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Move to the negedge; on a stall->run transition pop the expected MEM data.
    task automatic half();
        @(negedge clk);
        if (rst_n && prev_stall && !stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty actual=completion required=none");
            end else begin
                chk("mem_data", mem_data, exp_q.pop_front());
            end
        end
        prev_stall = rst_n ? stall : 1'b0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        dmem_ack   = 1'b0;
        wb_in      = 2'b00;
        alu_in     = 32'h0;
        store_data = 32'h0;
        rwa_in     = 5'd0;
    endtask

    // One memory access; ack is given in WAIT cycle nwait-1.
    task automatic mem_op(input logic st, input logic both, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input logic [1:0] wb, input logic [4:0] rwa, input int nwait);
        int stalls = 0;
        int reqc   = 0;
        mem_read   = both | ~st;
        mem_write  = st;
        alu_in     = alu;
        store_data = wd;
        wb_in      = wb;
        rwa_in     = rwa;
        if (!st) model_rdata = rd;
        exp_q.push_back(model_rdata);
        half();
        chk("idle_op_stall", 32'(stall), 32'd1);
        chk("idle_op_wb", 32'(wb_out), 32'(WB_BUBBLE));
        chk("alu_pass", alu_out, alu);
        chk("rwa_pass", 32'(rwa_out), 32'(rwa));
        if (stall) stalls++;
        adv();
        chk("req_issue", 32'(dmem_req), 32'd1);
        chk("we", 32'(dmem_we), 32'(st));
        chk("addr", dmem_addr, {alu[31:2], 2'b00});
        if (st) chk("wdata", dmem_wdata, wd);
        for (int i = 0; i < nwait; i++) begin
            if (dmem_req) reqc++;
            if (i == nwait - 1) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rd;
            end
            half();
            if (stall) stalls++;
            chk("wait_wb", 32'(wb_out), 32'(WB_BUBBLE));
            adv();
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
        end
        half();
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_wb", 32'(wb_out), 32'(wb));
        chk("done_req", 32'(dmem_req), 32'd0);
        chk("stall_cycles", 32'(stalls), 32'(nwait + 1));
        chk("req_cycles", 32'(reqc), 32'(nwait));
        adv();
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'b00, 32'h0000_0000, 5'd0,  2'b00, 1'b0};
        vecs[1] = '{2'b10, 32'h1234_5678, 5'd3,  2'b10, 1'b0};
        vecs[2] = '{2'b11, 32'hFFFF_FFFF, 5'd31, 2'b11, 1'b0};
        vecs[3] = '{2'b01, 32'h8000_0001, 5'd17, 2'b01, 1'b0};
        vecs[4] = '{2'b10, 32'hA5A5_5A5A, 5'd9,  2'b10, 1'b0};
        vecs[5] = '{2'b11, 32'h0000_1003, 5'd1,  2'b11, 1'b0};

        model_rdata = 32'h0;
        prev_stall  = 1'b0;
        dmem_rdata  = 32'h0;
        rst_n       = 1'b0;
        idle_inputs();
        mem_read = 1'b1;
        wb_in    = 2'b11;
        #3;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_wb", 32'(wb_out), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_mem_data", mem_data, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        idle_inputs();
        adv();
        adv();
        rst_n = 1'b1;
        adv();

        // Non-memory stream through the scoreboard.
        for (int i = 0; i < 6; i++) begin
            wb_in  = vecs[i].wb;
            alu_in = vecs[i].alu;
            rwa_in = vecs[i].rwa;
            vq.push_back('{vecs[i].exp_wb, vecs[i].exp_stall, vecs[i].alu, vecs[i].rwa});
            half();
            begin
                vexp_t e;
                e = vq.pop_front();
                chk("vec_wb", 32'(wb_out), 32'(e.wb));
                chk("vec_stall", 32'(stall), 32'(e.stall));
                chk("vec_alu", alu_out, e.alu);
                chk("vec_rwa", 32'(rwa_out), 32'(e.rwa));
                chk("vec_req", 32'(dmem_req), 32'd0);
            end
            adv();
        end
        idle_inputs();

        // Load with ack in the first WAIT cycle.
        mem_op(1'b0, 1'b0, 32'h0000_1007, 32'h0, 32'hCAFE_F00D,
               2'(1 << WB_REGWRITE) | 2'(1 << WB_MEMTOREG), 5'd7, 1);
        // Store acked after four WAIT cycles; load data must be kept.
        mem_op(1'b1, 1'b0, 32'h0000_2002, 32'h1234_5678, 32'hDEAD_0000, 2'b00, 5'd0, 4);
        // Read and write together behave as a store.
        mem_op(1'b1, 1'b1, 32'h0000_300F, 32'h0BAD_CAFE, 32'h1111_1111, 2'b00, 5'd2, 2);
        chk("store_keeps_rdata", mem_data, 32'hCAFE_F00D);

        // Spurious ack while idle.
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        half();
        chk("spur_stall", 32'(stall), 32'd0);
        adv();
        dmem_ack = 1'b0;
        half();
        chk("spur_mem_data", mem_data, model_rdata);
        chk("spur_req", 32'(dmem_req), 32'd0);
        adv();

        // Asynchronous reset in the middle of WAIT.
        mem_write  = 1'b1;
        alu_in     = 32'h0000_4000;
        store_data = 32'h5555_AAAA;
        wb_in      = 2'b11;
        half();
        adv();
        chk("mid_wait_req", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_req", 32'(dmem_req), 32'd0);
        chk("async_stall", 32'(stall), 32'd0);
        chk("async_wb", 32'(wb_out), 32'd0);
        model_rdata = 32'h0;
        prev_stall  = 1'b0;
        idle_inputs();
        adv();
        rst_n = 1'b1;
        wb_in = 2'b10;
        half();
        chk("post_rst_stall", 32'(stall), 32'd0);
        chk("post_rst_wb", 32'(wb_out), 32'd2);
        chk("post_rst_mem_data", mem_data, 32'h0);
        adv();
        chk("post_rst_req", 32'(dmem_req), 32'd0);
        idle_inputs();

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after eight WAIT cycles.
        begin
            int n = 0;
            mem_op(1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h7777_7777, 2'b11, 5'd4, 1);
            mem_read = 1'b1;
            alu_in   = 32'h0000_0080;
            wb_in    = 2'b10;
            model_rdata = 32'h0;
            exp_q.push_back(32'h0);
            half();
            adv();
            while (dmem_req && n < 20) begin
                n++;
                half();
                adv();
            end
            half();
            chk("to_wait_cycles", 32'(n), 32'd8);
            chk("to_err", 32'(err), 32'd1);
            chk("to_resume_wb", 32'(wb_out), 32'd2);
            adv();
            idle_inputs();
            half();
            adv();
            chk("to_err_sticky", 32'(err), 32'd1);
        end
`else
        chk("err_tied", 32'(err), 32'd0);
`endif

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
